bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Shares the single-port word-addressed RAM bus between two masters: m0 (CPU) and m1 (loader/DMA).
//  Per-master req/ack handshake; rd data routed back with a per-master rvalid one cycle after accept.
//  Fairness: round-robin with a bounded burst window, so one master cannot starve the other.
// PARAMETERS
//  MAX_BURST   4   max consecutive grants to the current owner while the other master waits (>=1)
// PORTS
//  clock       in   1   system clock, all state on posedge
//  reset       in   1   asynchronous, active-high reset
//  mN_req      in   1   mN access request (N = 0,1); held with addr/data/mask until mN_ack
//  mN_addr     in   30  mN word address
//  mN_data_w   in   32  mN write data
//  mN_mask_w   in   4   mN byte write enables; 0 = read
//  mN_ack      out  1   mN access accepted this cycle (combinational)
//  mN_rvalid   out  1   mN_data_r valid (registered; cycle after a read ack)
//  mN_data_r   out  32  mN read data (= bus_data_r, qualified by mN_rvalid)
//  bus_addr    out  30  RAM word address
//  bus_data_w  out  32  RAM write data
//  bus_mask_w  out  4   RAM byte write enables; 0 when no grant
//  bus_data_r  in   32  RAM read data, valid the cycle after address (1-cycle synchronous RAM)
// BEHAVIOUR
//  State: owner in {IDLE, OWN0, OWN1}; burst_cnt [$clog2(MAX_BURST+1)-1:0].
//  Grant (combinational from req + state):
//   - no req: no grant; bus_mask_w=0; bus_addr/bus_data_w hold last granted values (registered copy).
//   - one req: grant it.
//   - both req, IDLE: grant m0.
//   - both req, OWNx: grant x if burst_cnt < MAX_BURST, else grant the other master.
//  Grant to master g: mg_ack=1; bus_addr/data_w/mask_w = mg_* same cycle; the other ack=0.
//  On posedge with grant g: owner<=OWNg; burst_cnt<= (owner==OWNg) ? min(burst_cnt+1,MAX_BURST) : 1.
//  No grant: owner<=IDLE, burst_cnt<=0.
//  Read (mask_w==0) accepted at edge k: mg_rvalid=1 during cycle k+1, mg_data_r=bus_data_r.
//  Write (mask_w!=0): committed at the ack edge; no rvalid.
//  Back-to-back: a master may be granted every cycle; rvalid pipelines 1:1 with read acks.
//  Switch master: no bubble; m0 read at k and m1 read at k+1 give m0_rvalid@k+1, m1_rvalid@k+2.
//  MAX_BURST=1 degenerates to strict alternation under contention.
//  Reset (async, any time): owner=IDLE, burst_cnt=0, both rvalid=0 immediately (in-flight read dropped),
//   held bus_addr/data_w=0; while reset high, acks=0 and bus_mask_w=0 regardless of req.
//  Masters must not change addr/data/mask while req=1 and ack=0; dropping req before ack is allowed.
// CONFIGURATION
//  BUS_ARBITER_STATS_EN defined: extra outputs
//   m0_grants, m1_grants  out 32  per-master accepted-access counters, wrap at 2^32
//   contention            out 32  cycles with both req high, wrap at 2^32
//   all 0 on reset, increment on posedge, readable combinationally.
//  Not defined: ports and counters absent; arbitration behaviour identical.
// TESTING
//  1 reset mid-read: m0 read ack at k, reset pulse before k+1 edge -> m0_rvalid=0, no later rvalid, owner IDLE.
//  2 m0 only: 3 reads addr 0x10,0x11,0x12 back-to-back -> acks 3 consecutive cycles, rvalid cycles +1, data = RAM words.
//  3 both req continuously, MAX_BURST=4, from IDLE -> grant sequence 0,0,0,0,1,1,1,1,0,... ; no idle cycle.
//  4 m1 write 0xDEADBEEF mask 4'b0011 to 0x20 then m0 read 0x20 -> m0_data_r low 16 bits 0xBEEF, upper bits unchanged.
//  5 both req same cycle after reset -> m0 ack first; m1 ack next cycle once m0 drops req.
//  6 STATS_EN: 10 cycles both req, then idle -> m0_grants+m1_grants=10, contention=10; reset -> all 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master RAM bus arbiter: round-robin with a MAX_BURST window; optional BUS_ARBITER_STATS_EN counters.
// Latency: ack is combinational with req; read rvalid/data follow one cycle after the read ack.
// Backpressure: a losing master keeps req asserted with stable addr/data/mask until it sees its ack.
module bus_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [29:0] m0_addr,
    input  logic [31:0] m0_data_w,
    input  logic [3:0]  m0_mask_w,
    output logic        m0_ack,
    output logic        m0_rvalid,
    output logic [31:0] m0_data_r,
    input  logic        m1_req,
    input  logic [29:0] m1_addr,
    input  logic [31:0] m1_data_w,
    input  logic [3:0]  m1_mask_w,
    output logic        m1_ack,
    output logic        m1_rvalid,
    output logic [31:0] m1_data_r,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_data_w,
    output logic [3:0]  bus_mask_w,
`ifdef BUS_ARBITER_STATS_EN
    output logic [31:0] m0_grants,
    output logic [31:0] m1_grants,
    output logic [31:0] contention,
`endif
    input  logic [31:0] bus_data_r
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    owner_t          owner_q, owner_d;
    logic [CW-1:0]   burst_q, burst_d;
    logic            gnt0, gnt1;
    logic [29:0]     hold_addr_q;
    logic [31:0]     hold_data_q;
    logic            rvalid0_q, rvalid1_q;

    // Arbitration and next-state; reset forces no grant so the bus stays quiet while held.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        owner_d = IDLE;
        burst_d = '0;

        if (!reset) begin
            if (m0_req && m1_req) begin
                case (owner_q)
                    OWN0: begin
                        gnt0 = (burst_q < BURST_LIMIT);
                        gnt1 = !(burst_q < BURST_LIMIT);
                    end
                    OWN1: begin
                        gnt1 = (burst_q < BURST_LIMIT);
                        gnt0 = !(burst_q < BURST_LIMIT);
                    end
                    default: gnt0 = 1'b1;
                endcase
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end

        if (gnt0) begin
            owner_d = OWN0;
            if (owner_q == OWN0)
                burst_d = (burst_q < BURST_LIMIT) ? burst_q + CW'(1) : burst_q;
            else
                burst_d = CW'(1);
        end else if (gnt1) begin
            owner_d = OWN1;
            if (owner_q == OWN1)
                burst_d = (burst_q < BURST_LIMIT) ? burst_q + CW'(1) : burst_q;
            else
                burst_d = CW'(1);
        end
    end

    always_comb begin
        bus_addr   = hold_addr_q;
        bus_data_w = hold_data_q;
        bus_mask_w = 4'b0000;
        if (gnt0) begin
            bus_addr   = m0_addr;
            bus_data_w = m0_data_w;
            bus_mask_w = m0_mask_w;
        end else if (gnt1) begin
            bus_addr   = m1_addr;
            bus_data_w = m1_data_w;
            bus_mask_w = m1_mask_w;
        end
    end

    assign m0_ack    = gnt0;
    assign m1_ack    = gnt1;
    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign m0_data_r = bus_data_r;
    assign m1_data_r = bus_data_r;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q <= IDLE;
            burst_q <= '0;
        end else begin
            owner_q <= owner_d;
            burst_q <= burst_d;
        end
    end

    // The RAM returns data one cycle after address, so rvalid is just a delayed read-ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            rvalid0_q <= gnt0 && (m0_mask_w == 4'b0000);
            rvalid1_q <= gnt1 && (m1_mask_w == 4'b0000);
            if (gnt0 || gnt1) begin
                hold_addr_q <= bus_addr;
                hold_data_q <= bus_data_w;
            end
        end
    end

`ifdef BUS_ARBITER_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m0_grants  <= '0;
            m1_grants  <= '0;
            contention <= '0;
        end else begin
            if (gnt0)
                m0_grants <= m0_grants + 32'd1;
            if (gnt1)
                m1_grants <= m1_grants + 32'd1;
            if (m0_req && m1_req)
                contention <= contention + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: ack table, hand-written corner sequences and random traffic vs a reference model.
module tb_bus_arbiter;
    localparam int MAX_BURST = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m1_req;
    logic [29:0] m0_addr, m1_addr;
    logic [31:0] m0_data_w, m1_data_w;
    logic [3:0]  m0_mask_w, m1_mask_w;
    logic        m0_ack, m1_ack, m0_rvalid, m1_rvalid;
    logic [31:0] m0_data_r, m1_data_r;
    logic [29:0] bus_addr;
    logic [31:0] bus_data_w;
    logic [3:0]  bus_mask_w;
    logic [31:0] bus_data_r;
`ifdef BUS_ARBITER_STATS_EN
    logic [31:0] m0_grants, m1_grants, contention;
`endif

    always #5 clock = ~clock;

    bus_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_data_w(m0_data_w), .m0_mask_w(m0_mask_w),
        .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_data_r(m0_data_r),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_data_w(m1_data_w), .m1_mask_w(m1_mask_w),
        .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_data_r(m1_data_r),
        .bus_addr(bus_addr), .bus_data_w(bus_data_w), .bus_mask_w(bus_mask_w),
`ifdef BUS_ARBITER_STATS_EN
        .m0_grants(m0_grants), .m1_grants(m1_grants), .contention(contention),
`endif
        .bus_data_r(bus_data_r)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // 1-cycle synchronous RAM seen by the arbiter
    logic [31:0] ram [0:255];
    logic        ram_ready = 1'b0;
    always @(posedge clock) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus_mask_w[b]) ram[bus_addr[7:0]][b*8 +: 8] <= bus_data_w[b*8 +: 8];
            bus_data_r <= ram[bus_addr[7:0]];
        end
    end

    // Reference model: last winner, length of its current run, expected read returns, memory image
    logic [31:0] ref_mem [0:255];
    int          m_last, m_run;
    bit          exp_rv0, exp_rv1, g0, g1;
    logic [31:0] exp_d0, exp_d1, m_hold_data;
    logic [29:0] m_hold_addr;
    bit          s_ack0, s_ack1, s_rv0, s_rv1;
    logic [31:0] s_d0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_last = -1; m_run = 0;
        exp_rv0 = 0; exp_rv1 = 0;
        m_hold_addr = '0; m_hold_data = '0;
    endtask

    task automatic predict();
        int pick;
        g0 = 0; g1 = 0;
        if (m0_req && m1_req) begin
            if (m_last < 0)              pick = 0;
            else if (m_run < MAX_BURST)  pick = m_last;
            else                         pick = 1 - m_last;
            g0 = (pick == 0);
            g1 = (pick == 1);
        end else begin
            g0 = m0_req;
            g1 = m1_req;
        end
    endtask

    // One bus cycle: entered just after a posedge, compares at negedge, advances the model at posedge.
    task automatic step();
        logic [29:0] ea;
        logic [31:0] ed;
        logic [3:0]  em;
        int          g;
        @(negedge clock);
        predict();
        ea = g0 ? m0_addr : g1 ? m1_addr : m_hold_addr;
        ed = g0 ? m0_data_w : g1 ? m1_data_w : m_hold_data;
        em = g0 ? m0_mask_w : g1 ? m1_mask_w : 4'b0000;
        s_ack0 = m0_ack; s_ack1 = m1_ack; s_rv0 = m0_rvalid; s_rv1 = m1_rvalid; s_d0 = m0_data_r;
        check("m0_ack", 32'(m0_ack), 32'(g0));
        check("m1_ack", 32'(m1_ack), 32'(g1));
        check("bus_mask_w", 32'(bus_mask_w), 32'(em));
        check("bus_addr", 32'(bus_addr), 32'(ea));
        check("bus_data_w", bus_data_w, ed);
        check("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv0));
        check("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv1));
        if (exp_rv0) check("m0_data_r", m0_data_r, exp_d0);
        if (exp_rv1) check("m1_data_r", m1_data_r, exp_d1);
        @(posedge clock);
        exp_rv0 = g0 && (m0_mask_w == 4'b0000);
        exp_rv1 = g1 && (m1_mask_w == 4'b0000);
        exp_d0  = ref_mem[m0_addr[7:0]];
        exp_d1  = ref_mem[m1_addr[7:0]];
        if (g0 || g1) begin
            for (int b = 0; b < 4; b++)
                if (em[b]) ref_mem[ea[7:0]][b*8 +: 8] = ed[b*8 +: 8];
            m_hold_addr = ea;
            m_hold_data = ed;
            g = g0 ? 0 : 1;
            if (g == m_last) m_run = (m_run < MAX_BURST) ? m_run + 1 : m_run;
            else             m_run = 1;
            m_last = g;
        end else begin
            m_last = -1;
            m_run  = 0;
        end
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clock);
        check("rst m0_ack", 32'(m0_ack), 32'd0);
        check("rst m1_ack", 32'(m1_ack), 32'd0);
        check("rst bus_mask_w", 32'(bus_mask_w), 32'd0);
        check("rst rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic drive(int m, bit req, logic [29:0] addr, logic [31:0] data, logic [3:0] mask);
        if (m == 0) begin m0_req = req; m0_addr = addr; m0_data_w = data; m0_mask_w = mask; end
        else        begin m1_req = req; m1_addr = addr; m1_data_w = data; m1_mask_w = mask; end
    endtask

    typedef struct {
        bit r0, r1;
        bit a0, a1;
    } vec_t;
    vec_t tbl [12];

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        // Contention from IDLE: four to m0, four to m1, back to m0; then lone requesters.
        for (int i = 0; i < 10; i++) tbl[i] = '{1, 1, (i < 4 || i >= 8), (i >= 4 && i < 8)};
        tbl[10] = '{1, 0, 1, 0};
        tbl[11] = '{0, 1, 0, 1};

        reset = 1'b1;
        drive(0, 0, '0, '0, '0);
        drive(1, 0, '0, '0, '0);
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        step();
        check("reset bus_addr", 32'(bus_addr), 32'd0);

        // m0 back-to-back reads 0x10..0x12
        drive(0, 1, 30'h10, 32'h0, 4'h0); step(); check("t2 ack0 a", 32'(s_ack0), 32'd1);
        drive(0, 1, 30'h11, 32'h0, 4'h0); step();
        check("t2 rv0 a", 32'(s_rv0), 32'd1); check("t2 data a", s_d0, 32'hA500_0010);
        drive(0, 1, 30'h12, 32'h0, 4'h0); step();
        check("t2 data b", s_d0, 32'hA500_0011);
        drive(0, 0, 30'h12, 32'h0, 4'h0); step();
        check("t2 data c", s_d0, 32'hA500_0012);
        step(); check("t2 rv0 end", 32'(s_rv0), 32'd0);

        // m1 partial write, then m0 reads the merged word
        drive(1, 1, 30'h20, 32'hDEAD_BEEF, 4'b0011); step();
        check("t4 ack1", 32'(s_ack1), 32'd1);
        drive(1, 0, 30'h20, 32'h0, 4'h0);
        drive(0, 1, 30'h20, 32'h0, 4'h0); step();
        drive(0, 0, 30'h20, 32'h0, 4'h0); step();
        check("t4 merged", s_d0, 32'hA500_BEEF);

        apply_reset();
        for (int i = 0; i < 12; i++) begin
            drive(0, tbl[i].r0, 30'h30, 32'h0, 4'h0);
            drive(1, tbl[i].r1, 30'h31, 32'h0, 4'h0);
            step();
            check($sformatf("tbl%0d ack0", i), 32'(s_ack0), 32'(tbl[i].a0));
            check($sformatf("tbl%0d ack1", i), 32'(s_ack1), 32'(tbl[i].a1));
        end
        drive(1, 0, 30'h31, 32'h0, 4'h0);
        step();

        // Simultaneous requests right after reset
        apply_reset();
        drive(0, 1, 30'h05, 32'h0, 4'h0);
        drive(1, 1, 30'h06, 32'h0, 4'h0);
        step(); check("t5 first m0", 32'(s_ack0), 32'd1); check("t5 first m1", 32'(s_ack1), 32'd0);
        drive(0, 0, 30'h05, 32'h0, 4'h0);
        step(); check("t5 then m1", 32'(s_ack1), 32'd1);
        drive(1, 0, 30'h06, 32'h0, 4'h0);
        step();

        // Reset between a read ack and its return
        drive(0, 1, 30'h12, 32'h0, 4'h0);
        step();
        check("t1 rvalid up", 32'(m0_rvalid), 32'd1);
        reset = 1'b1;
        #1;
        check("t1 rvalid dropped", 32'(m0_rvalid), 32'd0);
        check("t1 ack in reset", 32'(m0_ack), 32'd0);
        check("t1 mask in reset", 32'(bus_mask_w), 32'd0);
        #1;
        reset = 1'b0;
        drive(0, 0, 30'h12, 32'h0, 4'h0);
        model_clear();
        repeat (2) step();
        check("t1 no late rvalid", 32'(s_rv0), 32'd0);
        drive(0, 1, 30'h13, 32'h0, 4'h0);
        drive(1, 1, 30'h14, 32'h0, 4'h0);
        step(); check("t1 idle owner", 32'(s_ack0), 32'd1);
        drive(0, 0, 30'h13, 32'h0, 4'h0);
        drive(1, 0, 30'h14, 32'h0, 4'h0);
        step();

        // Random traffic; a master only changes its request after being accepted or while idle
        for (int i = 0; i < 400; i++) begin
            step();
            if (!m0_req || g0)
                drive(0, $urandom_range(0, 3) != 0, 30'($urandom_range(0, 63)), $urandom,
                      ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15)));
            else if ($urandom_range(0, 15) == 0)
                m0_req = 1'b0;
            if (!m1_req || g1)
                drive(1, $urandom_range(0, 3) != 0, 30'($urandom_range(0, 63)), $urandom,
                      ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15)));
            else if ($urandom_range(0, 15) == 0)
                m1_req = 1'b0;
        end
        drive(0, 0, '0, '0, '0);
        drive(1, 0, '0, '0, '0);
        step();

`ifdef BUS_ARBITER_STATS_EN
        apply_reset();
        check("stats zero", m0_grants | m1_grants | contention, 32'd0);
        drive(0, 1, 30'h01, 32'h0, 4'h0);
        drive(1, 1, 30'h02, 32'h0, 4'h0);
        repeat (10) step();
        drive(0, 0, 30'h01, 32'h0, 4'h0);
        drive(1, 0, 30'h02, 32'h0, 4'h0);
        step();
        check("stats grants", m0_grants + m1_grants, 32'd10);
        check("stats contention", contention, 32'd10);
        reset = 1'b1;
        #1;
        check("stats reset", m0_grants | m1_grants | contention, 32'd0);
        #1;
        reset = 1'b0;
        model_clear();
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
